// File: rtl/fibo_controller.sv
// Control FSM sequencing a 4-entry register-file datapath through the first n Fibonacci terms.
// Optional FIBO_STEP_EN adds a step input that gates each READ->WRITE advance.
module fibo_controller #(
   parameter int unsigned      size    = 4,
   parameter logic [size-2:0]  OP_PASS = 3'b001,
   parameter logic [size-2:0]  OP_ADD  = 3'b110
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [size-1:0]   n,
   input  logic              zero_flag,
`ifdef FIBO_STEP_EN
   input  logic              step,
`endif
   output logic [size-3:0]   wrt_addr,
   output logic              wrt_en,
   output logic              load_data,
   output logic [size-3:0]   rd_addr1,
   output logic [size-3:0]   rd_addr2,
   output logic [size-2:0]   alu_opcode,
   output logic [size-1:0]   count,
   output logic              busy,
   output logic              done,
   output logic              result_zero
);

   localparam int unsigned AW = size - 2;

   localparam logic [AW-1:0]   ADDR_ZERO = '0;
   localparam logic [AW-1:0]   ADDR_ONE  = AW'(1'b1);
   localparam logic [AW-1:0]   WP_START  = AW'(2'd2);
   localparam logic [size-1:0] CNT_ZERO  = '0;
   localparam logic [size-1:0] CNT_ONE   = size'(1'b1);
   localparam logic [size-1:0] CNT_TWO   = size'(2'd2);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD0 = 3'd1,
      LOAD1 = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state_r;
   state_t            next_state_s;
   logic [AW-1:0]     wp_r;
   logic [AW-1:0]     last_addr_r;
   logic [AW-1:0]     n_lo_r;
   logic [size-1:0]   rem_r;

   logic [AW-1:0]     wrt_addr_s;
   logic              wrt_en_s;
   logic              load_data_s;
   logic [AW-1:0]     rd_addr1_s;
   logic [AW-1:0]     rd_addr2_s;
   logic [size-2:0]   alu_opcode_s;
   logic [size-1:0]   count_s;
   logic              busy_s;
   logic              done_s;

   // State register plus the run bookkeeping (write pointer, remaining adds, last address, zero flag)
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         wp_r        <= WP_START;
         rem_r       <= CNT_ZERO;
         last_addr_r <= ADDR_ZERO;
         n_lo_r      <= ADDR_ZERO;
         result_zero <= 1'b0;
      end else begin
         state_r <= next_state_s;
         case (state_r)
            IDLE: begin
               if (start && (n != CNT_ZERO)) begin
                  rem_r       <= (n > CNT_TWO) ? (n - CNT_TWO) : CNT_ZERO;
                  n_lo_r      <= n[AW-1:0];
                  wp_r        <= WP_START;
                  result_zero <= 1'b0;
               end
            end
            LOAD1: begin
               if (rem_r == CNT_ZERO) begin
                  last_addr_r <= n_lo_r - ADDR_ONE;
               end
            end
            WRITE: begin
               // zero_flag here reflects the sum currently presented on the read addresses
               result_zero <= result_zero | zero_flag;
               wp_r        <= wp_r + ADDR_ONE;
               last_addr_r <= wp_r;
               if (rem_r != CNT_ZERO) begin
                  rem_r <= rem_r - CNT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = (n == CNT_ZERO) ? DONE : LOAD0;
            end else begin
               next_state_s = IDLE;
            end
         end
         LOAD0:   next_state_s = LOAD1;
         LOAD1:   next_state_s = (rem_r == CNT_ZERO) ? DONE : READ;
`ifdef FIBO_STEP_EN
         READ:    next_state_s = step ? WRITE : READ;
`else
         READ:    next_state_s = WRITE;
`endif
         WRITE:   next_state_s = (rem_r <= CNT_ONE) ? DONE : READ;
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Output decode from the current state
   always_comb begin
      wrt_addr_s   = ADDR_ZERO;
      wrt_en_s     = 1'b0;
      load_data_s  = 1'b0;
      rd_addr1_s   = last_addr_r;
      rd_addr2_s   = ADDR_ZERO;
      alu_opcode_s = OP_PASS;
      count_s      = CNT_ZERO;
      busy_s       = 1'b1;
      done_s       = 1'b0;
      case (state_r)
         IDLE: busy_s = 1'b0;
         LOAD0, LOAD1: begin
            wrt_en_s    = 1'b1;
            load_data_s = 1'b1;
            wrt_addr_s  = (state_r == LOAD1) ? ADDR_ONE : ADDR_ZERO;
            rd_addr1_s  = ADDR_ZERO;
            count_s     = CNT_ONE;
         end
         READ, WRITE: begin
            rd_addr1_s   = wp_r - ADDR_ONE;
            rd_addr2_s   = wp_r - WP_START;
            alu_opcode_s = OP_ADD;
            count_s      = rem_r;
            wrt_addr_s   = wp_r;
            wrt_en_s     = (state_r == WRITE);
         end
         DONE:    done_s = 1'b1;
         default: busy_s = 1'b0;
      endcase
   end

   // Output register; the datapath therefore sees each state's controls one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         wrt_addr   <= ADDR_ZERO;
         wrt_en     <= 1'b0;
         load_data  <= 1'b0;
         rd_addr1   <= ADDR_ZERO;
         rd_addr2   <= ADDR_ZERO;
         alu_opcode <= OP_PASS;
         count      <= CNT_ZERO;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         wrt_addr   <= wrt_addr_s;
         wrt_en     <= wrt_en_s;
         load_data  <= load_data_s;
         rd_addr1   <= rd_addr1_s;
         rd_addr2   <= rd_addr2_s;
         alu_opcode <= alu_opcode_s;
         count      <= count_s;
         busy       <= busy_s;
         done       <= done_s;
      end
   end

endmodule

// File: tb/tb_fibo_controller.sv
// Scoreboard bench for fibo_controller: a register-file/adder datapath model closes the loop,
// expected results come from a plain Fibonacci-mod-16 reference computed per request.
module tb_fibo_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] n = 4'd0;
   logic       zero_flag;
`ifdef FIBO_STEP_EN
   logic       step = 1'b1;
`endif
   logic [1:0] wrt_addr;
   logic       wrt_en;
   logic       load_data;
   logic [1:0] rd_addr1;
   logic [1:0] rd_addr2;
   logic [2:0] alu_opcode;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       result_zero;

   always #5 clk = ~clk;

   fibo_controller dut (
      .clk(clk), .reset(reset), .start(start), .n(n), .zero_flag(zero_flag),
`ifdef FIBO_STEP_EN
      .step(step),
`endif
      .wrt_addr(wrt_addr), .wrt_en(wrt_en), .load_data(load_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .alu_opcode(alu_opcode),
      .count(count), .busy(busy), .done(done), .result_zero(result_zero)
   );

   // Datapath model: 4x4 register file, ALU passes operand A or adds A+B
   logic [3:0] rf [4];
   logic [3:0] alu;
   logic [3:0] data;
   always_comb alu = (alu_opcode == 3'b110) ? 4'(rf[rd_addr1] + rf[rd_addr2]) : rf[rd_addr1];
   assign zero_flag = (alu == 4'd0);
   assign data = rf[rd_addr1];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
      end else if (wrt_en) begin
         rf[wrt_addr] <= load_data ? count : alu;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         n;
      int         k;
      int         lat;
      bit         chk_lat;
      bit         chk_data;
      logic [3:0] data;
      logic [1:0] la;
      logic       rz;
      int         writes;
   } exp_t;

   exp_t       q[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         wr_cnt = 0;
   logic       prev_rz = 1'b0;
   logic [1:0] prev_la = 2'd0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference: Fibonacci terms mod 16, seeds 1,1, computed terms 3..n
   function automatic exp_t model(input int nn, input int k, input bit chk_lat);
      exp_t e;
      int a = 1, b = 1, c;
      logic rz = 1'b0;
      for (int i = 3; i <= nn; i++) begin
         c = (a + b) % 16;
         if (c == 0) rz = 1'b1;
         a = b;
         b = c;
      end
      e.n        = nn;
      e.k        = k;
      e.chk_lat  = chk_lat;
      e.lat      = (nn == 0) ? 1 : 3 + 2 * ((nn > 2) ? nn - 2 : 0);
      e.chk_data = (nn != 0);
      e.data     = 4'(b);
      e.writes   = (nn == 0) ? 0 : 2 + ((nn > 2) ? nn - 2 : 0);
      if (nn != 0) begin
         prev_la = 2'((nn - 1) % 4);
         prev_rz = rz;
      end
      e.la = prev_la;
      e.rz = prev_rz;
      return e;
   endfunction

   // Monitor: counts writes and scores each completion against the queue head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            wr_cnt = 0;
         end else begin
            if (wrt_en) wr_cnt++;
            if (done) begin
               if (q.size() == 0) begin
                  check("spurious_done", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  if (e.chk_lat) check("latency", 32'(cyc - e.k), 32'(e.lat));
                  if (e.chk_data) check("data", 32'(data), 32'(e.data));
                  check("last_addr", 32'(rd_addr1), 32'(e.la));
                  check("result_zero", 32'(result_zero), 32'(e.rz));
                  check("writes", 32'(wr_cnt), 32'(e.writes));
                  check("done_opcode", 32'(alu_opcode), 32'd1);
                  check("done_count", 32'(count), 32'd0);
                  wr_cnt = 0;
               end
            end
         end
      end
   end

   task automatic do_run(input int nn, input bit chk_lat);
      @(negedge clk);
      start = 1'b1;
      n     = 4'(nn);
      q.push_back(model(nn, cyc + 1, chk_lat));
      @(negedge clk);
      start = 1'b0;
      n     = 4'($urandom_range(0, 15));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (q.size() == 0) break;
         @(negedge clk);
      end
      if (q.size() != 0) begin
         check("timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic pulse_start_while_busy(input int gap);
      repeat (gap) @(negedge clk);
      if (busy && !done) begin
         start = 1'b1;
         n     = 4'($urandom_range(0, 15));
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_wrt_en", 32'(wrt_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_opcode", 32'(alu_opcode), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_rd_addr1", 32'(rd_addr1), 32'd0);
      check("rst_result_zero", 32'(result_zero), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed: n=5, n=12 (wrap to 0), n=0, n=1
      do_run(5, 1'b1);  wait_idle();
      do_run(12, 1'b1); wait_idle();
      do_run(0, 1'b1);  wait_idle();
      do_run(1, 1'b1);  wait_idle();
      do_run(2, 1'b1);  wait_idle();

      // Start while busy is ignored
      do_run(7, 1'b1);
      pulse_start_while_busy(3);
      wait_idle();

      // Reset in the middle of an n=9 run
      do_run(9, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (wrt_en && !load_data) begin
            seen = 1'b1;
            break;
         end
      end
      check("saw_add_write", 32'(seen), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_wrt_en", 32'(wrt_en), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      q.delete();
      prev_la = 2'd0;
      prev_rz = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle", 32'(busy), 32'd0);
      do_run(4, 1'b1); wait_idle();

`ifdef FIBO_STEP_EN
      // Single-step: READ holds until step is sampled
      step = 1'b0;
      do_run(4, 1'b0);
      repeat (8) @(negedge clk);
      #1;
      check("step_hold_busy", 32'(busy), 32'd1);
      check("step_hold_writes", 32'(wr_cnt), 32'd2);
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("step_one_writes", 32'(wr_cnt), 32'd3);
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      wait_idle();
      step = 1'b1;
`endif

      // Randomized runs with occasional ignored starts
      for (int r = 0; r < 30; r++) begin
         do_run($urandom_range(0, 15), 1'b1);
         if ($urandom_range(0, 2) == 0) pulse_start_while_busy($urandom_range(0, 6));
         wait_idle();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
